weighted_rr_arbiter: RTL
========================

WEIGHTED_RR_ARBITER -- requirements
Module: weighted_rr_arbiter

Interface
REQ-001 SHALL have parameter PORTS, default 4, number of requesters; legal range 2..32.
REQ-002 SHALL have parameter QUANTUM_W, default 4, width of the hold-quantum input.
REQ-003 SHALL derive localparam IDX_W = $clog2(PORTS).
REQ-004 SHALL have port i_clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port i_rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_req  input  PORTS  per-port request level, held until served.
REQ-007 SHALL have port i_quantum  input  QUANTUM_W  max consecutive grant cycles per holder while others wait; sampled every cycle.
REQ-008 SHALL have port i_lock  input  1  while high, the current holder keeps the grant regardless of quantum.
REQ-009 SHALL have port o_grant  output  PORTS  registered one-hot grant, or all zero.
REQ-010 SHALL have port o_grant_idx  output  IDX_W  registered index of the holder; 0 when idle.
REQ-011 SHALL have port o_grant_valid  output  1  registered; high iff o_grant is nonzero.

Function
REQ-012 SHALL implement FSM states S_IDLE (no holder) and S_GRANT (one holder).
REQ-013 S_IDLE: any i_req bit high at edge N -> S_GRANT; grant is visible after edge N, so latency is 1 cycle.
REQ-014 Selection SHALL be round-robin: search starts at r_ptr+1 mod PORTS and wraps; r_ptr is the last granted index.
REQ-015 S_GRANT hold: the holder keeps the grant while its i_req is high and the quantum has not expired.
REQ-016 A quantum counter SHALL clear on each new grant and increment each held cycle; it expires when count+1 >= max(i_quantum,1).
REQ-017 Release: if holder i_req is low, re-arbitrate in the same cycle from holder+1; if a winner exists, it is granted next cycle with no idle bubble, else -> S_IDLE with o_grant=0.
REQ-018 Quantum expiry with another port requesting SHALL switch to the next requester after holder, with no bubble.
REQ-019 Quantum expiry with only the holder requesting SHALL keep the grant and clear the counter.
REQ-020 i_lock high SHALL suppress quantum-expiry switching; the counter saturates. It SHALL NOT override a release (holder i_req low).
REQ-021 i_quantum=0 SHALL behave as 1; a QUANTUM_W all-ones counter SHALL NOT wrap.
REQ-022 r_ptr SHALL update only when a new grant is issued; wrap from PORTS-1 to 0.
REQ-023 Simultaneous release and expiry SHALL be treated as release.
REQ-024 o_grant SHALL never have more than one bit set, and never grant a port whose i_req was low at the deciding edge.

Reset
REQ-025 On i_rstn low, all state SHALL clear immediately without waiting for a clock edge: S_IDLE, o_grant=0, o_grant_idx=0, o_grant_valid=0, counter=0, r_ptr=PORTS-1, so the first search starts at port 0.
REQ-026 Reset mid-grant SHALL drop the grant immediately; the first grant after release is 1 cycle after the first edge that sees a request.

Structure
REQ-027 SHALL place the state enum (S_IDLE, S_GRANT) in a shared package, arb_pkg.
REQ-028 SHALL reuse the existing masked_priority_encoder sub-module, with i_vec=i_req and i_idx=search start, for next-index selection.
REQ-029 All outputs SHALL be driven directly from flops; next-state logic SHALL be a single combinational block.

Verification
REQ-030 Reset release with PORTS=4, i_req=4'b1111, i_quantum=2, i_lock=0 -> grants 0,0,1,1,2,2,3,3,0... with o_grant_valid high every cycle after the first edge.
REQ-031 i_req=4'b0100 for 3 cycles, then 0 -> grant idx 2 for 3 cycles, then o_grant=0 and S_IDLE next cycle.
REQ-032 Holder 1 drops its request while i_req[3] is high -> o_grant=4'b1000 on the next cycle, no bubble.
REQ-033 i_quantum=1, i_lock=1, holder 0, i_req=4'b0011 for 5 cycles -> port 0 held all 5 cycles; after i_lock falls, port 1 is granted next cycle.
REQ-034 Only port 2 requests with i_quantum=0 -> port 2 held continuously, no deassert glitch.
REQ-035 Assert i_rstn low asynchronously between edges during a grant -> o_grant=0 before the next edge; after release with i_req=4'b1010 -> port 1 granted first.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types for the weighted round-robin arbiter.
package arb_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/masked_priority_encoder.sv
// Circular priority encoder: the first set bit of i_vec at or after i_idx, wrapping.
module masked_priority_encoder #(
  parameter int WIDTH = 4,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_vec,
  input  logic [IDX_W-1:0] i_idx,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  logic [IDX_W:0] pos;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    pos     = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      pos = {1'b0, i_idx} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(WIDTH)) pos = pos - (IDX_W+1)'(WIDTH);
      if (i_vec[pos[IDX_W-1:0]]) begin
        o_idx   = pos[IDX_W-1:0];
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Round-robin arbiter with a per-grant hold quantum and a lock that pins the holder.
module weighted_rr_arbiter
  import arb_pkg::*;
#(
  parameter int PORTS     = 4,
  parameter int QUANTUM_W = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic [PORTS-1:0]         i_req,
  input  logic [QUANTUM_W-1:0]     i_quantum,
  input  logic                     i_lock,
  output logic [PORTS-1:0]         o_grant,
  output logic [$clog2(PORTS)-1:0] o_grant_idx,
  output logic                     o_grant_valid
);

  localparam int IDX_W = $clog2(PORTS);
  localparam logic [IDX_W-1:0]     LAST    = IDX_W'(PORTS - 1);
  localparam logic [QUANTUM_W-1:0] CNT_MAX = '1;

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [QUANTUM_W-1:0]   cnt_q, cnt_d;
  logic [PORTS-1:0]       grant_d;
  logic [IDX_W-1:0]       idx_d;
  logic                   valid_d;

  logic [IDX_W-1:0]       start;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_found;
  logic [QUANTUM_W-1:0]   qmax;
  logic                   expired;
  logic [QUANTUM_W-1:0]   cnt_inc;
  logic                   holder_req;
  logic                   take;

  // ptr_q tracks the holder while granted, so one search start serves both states.
  assign start      = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
  assign qmax       = (i_quantum == '0) ? QUANTUM_W'(1) : i_quantum;
  assign expired    = ({1'b0, cnt_q} + (QUANTUM_W+1)'(1)) >= {1'b0, qmax};
  assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign holder_req = i_req[o_grant_idx];

  masked_priority_encoder #(
    .WIDTH (PORTS),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_vec   (i_req),
    .i_idx   (start),
    .o_idx   (win_idx),
    .o_found (win_found)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = o_grant;
    idx_d   = o_grant_idx;
    valid_d = o_grant_valid;
    take    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (win_found) take = 1'b1;
      end
      S_GRANT: begin
        if (!holder_req) begin
          if (win_found) begin
            take = 1'b1;
          end else begin
            state_d = S_IDLE;
            grant_d = '0;
            idx_d   = '0;
            valid_d = 1'b0;
            cnt_d   = '0;
          end
        end else if (i_lock) begin
          cnt_d = cnt_inc;
        end else if (expired) begin
          // Search wraps back to the holder only when nobody else is asking.
          if (win_idx != o_grant_idx) take = 1'b1;
          else                        cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take) begin
      state_d          = S_GRANT;
      ptr_d            = win_idx;
      cnt_d            = '0;
      grant_d          = '0;
      grant_d[win_idx] = 1'b1;
      idx_d            = win_idx;
      valid_d          = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q       <= S_IDLE;
      ptr_q         <= LAST;
      cnt_q         <= '0;
      o_grant       <= '0;
      o_grant_idx   <= '0;
      o_grant_valid <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      o_grant       <= grant_d;
      o_grant_idx   <= idx_d;
      o_grant_valid <= valid_d;
    end
  end

  a_onehot : assert property (@(posedge i_clk) disable iff (!i_rstn)
    $onehot0(o_grant) && (o_grant_valid == (o_grant != '0)));

endmodule
